// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings,
// mstatus/mie bit positions and fixed read values.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;

    localparam logic [31:0] MISA_VAL    = 32'h4000_0100;
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
endpackage

// File: rtl/csr_counter64.sv
// One 64-bit free-running counter with independently writable 32-bit halves.
module csr_counter64 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wd,
    output logic [63:0] o_cnt
);
    logic [63:0] r_cnt;

    // A half-write suppresses the whole increment, so no carry leaks out of a written low word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        r_cnt <= '0;
        else if (i_wr_lo) r_cnt[31:0]  <= i_wd;
        else if (i_wr_hi) r_cnt[63:32] <= i_wd;
        else if (i_inc)   r_cnt <= r_cnt + 64'd1;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: atomic RW/RS/RC access, trap/mret bookkeeping,
// 64-bit cycle/instret counters and illegal-access detection.
module csr_file
    import csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [11:0]     i_csr,
    input  logic [1:0]      i_csr_op,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd,
    output logic            o_illegal,
    input  logic            i_retire,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_val,
    input  logic            i_mret,
    input  logic            i_irq_ext,
    output logic            o_irq_take,
    output logic [XLEN-1:0] o_mtvec,
    output logic [XLEN-1:0] o_mepc
);
    logic            r_mie, r_mpie, r_meie;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [63:0]     w_cyc, w_inst;
    logic [XLEN-1:0] w_old, w_new, w_mstatus;
    logic            w_impl, w_sys, w_we;

    always_comb begin
        w_mstatus               = MSTATUS_RST;
        w_mstatus[MSTATUS_MIE]  = r_mie;
        w_mstatus[MSTATUS_MPIE] = r_mpie;
    end

    always_comb begin
        w_impl = 1'b1;
        w_old  = '0;
        case (i_csr)
            CSR_MSTATUS:   w_old = w_mstatus;
            CSR_MISA:      w_old = MISA_VAL;
            CSR_MIE:       w_old[MIE_MEIE] = r_meie;
            CSR_MTVEC:     w_old = r_mtvec;
            CSR_MSCRATCH:  w_old = r_mscratch;
            CSR_MEPC:      w_old = r_mepc;
            CSR_MCAUSE:    w_old = r_mcause;
            CSR_MTVAL:     w_old = r_mtval;
            CSR_MIP:       w_old[MIE_MEIE] = i_irq_ext;
            CSR_MCYCLE:    w_old = w_cyc[31:0];
            CSR_MCYCLEH:   w_old = w_cyc[63:32];
            CSR_MINSTRET:  w_old = w_inst[31:0];
            CSR_MINSTRETH: w_old = w_inst[63:32];
            CSR_MHARTID:   w_old = HART_ID;
            default:       w_impl = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_e'(i_csr_op))
            OP_RW:   w_new = i_wd;
            OP_RS:   w_new = w_old | i_wd;
            OP_RC:   w_new = w_old & ~i_wd;
            default: w_new = w_old;
        endcase
    end

    // The 0xC00-0xFFF range is read-only: only a set/clear with a zero mask is a legal read.
    assign w_sys     = (i_csr[11:10] == 2'b11);
    assign o_illegal = (i_csr_op != OP_NONE) &&
                       (!w_impl || (w_sys && (i_csr_op == OP_RW || i_wd != '0)));
    assign w_we      = (i_csr_op != OP_NONE) && !o_illegal;

    assign o_rd       = w_old;
    assign o_irq_take = i_irq_ext & r_meie & r_mie;
    assign o_mtvec    = r_mtvec;
    assign o_mepc     = r_mepc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_meie     <= 1'b0;
            r_mtvec    <= MTVEC_RST;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else begin
            if (i_trap) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end else if (i_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_we && i_csr == CSR_MSTATUS) begin
                r_mie  <= w_new[MSTATUS_MIE];
                r_mpie <= w_new[MSTATUS_MPIE];
            end
            if (i_trap) begin
                r_mepc   <= {i_trap_pc[XLEN-1:2], 2'b00};
                r_mcause <= i_trap_cause;
                r_mtval  <= i_trap_val;
            end else if (w_we) begin
                if (i_csr == CSR_MEPC)   r_mepc   <= {w_new[XLEN-1:2], 2'b00};
                if (i_csr == CSR_MCAUSE) r_mcause <= w_new;
                if (i_csr == CSR_MTVAL)  r_mtval  <= w_new;
            end
            if (w_we && i_csr == CSR_MIE)      r_meie     <= w_new[MIE_MEIE];
            if (w_we && i_csr == CSR_MTVEC)    r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
            if (w_we && i_csr == CSR_MSCRATCH) r_mscratch <= w_new;
        end
    end

    csr_counter64 u_mcycle (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_we && i_csr == CSR_MCYCLE),
        .i_wr_hi (w_we && i_csr == CSR_MCYCLEH),
        .i_wd    (w_new),
        .o_cnt   (w_cyc)
    );

    csr_counter64 u_minstret (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (i_retire),
        .i_wr_lo (w_we && i_csr == CSR_MINSTRET),
        .i_wr_hi (w_we && i_csr == CSR_MINSTRETH),
        .i_wd    (w_new),
        .o_cnt   (w_inst)
    );
endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed vector table, hand-written trap/counter/reset
// sequences, then random traffic checked against a behavioural model.
module tb_csr_file;
    localparam logic [31:0] HART     = 32'h0000_0003;
    localparam logic [31:0] TVEC_RST = 32'h0000_0100;

    logic        i_clk, i_rst;
    logic [11:0] i_csr;
    logic [1:0]  i_csr_op;
    logic [31:0] i_wd, o_rd, i_trap_cause, i_trap_pc, i_trap_val, o_mtvec, o_mepc;
    logic        o_illegal, i_retire, i_trap, i_mret, i_irq_ext, o_irq_take;

    csr_file #(.XLEN(32), .HART_ID(HART), .MTVEC_RST(TVEC_RST)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_csr(i_csr), .i_csr_op(i_csr_op), .i_wd(i_wd),
        .o_rd(o_rd), .o_illegal(o_illegal), .i_retire(i_retire), .i_trap(i_trap),
        .i_trap_cause(i_trap_cause), .i_trap_pc(i_trap_pc), .i_trap_val(i_trap_val),
        .i_mret(i_mret), .i_irq_ext(i_irq_ext), .o_irq_take(o_irq_take),
        .o_mtvec(o_mtvec), .o_mepc(o_mepc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0, fails = 0;

    // Reference state: mstatus as two flags, counters as plain 64-bit numbers.
    logic        m_mie, m_mpie, m_meie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0;
        m_mtvec = TVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_inst = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 0) + (m_mie ? 32'h8 : 0);
            12'h301: return 32'h4000_0100;
            12'h304: return m_meie ? 32'h800 : 0;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return i_irq_ext ? 32'h800 : 0;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_inst[31:0];
            12'hB82: return m_inst[63:32];
            12'hF14: return HART;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction

    function automatic bit m_illegal();
        if (i_csr_op == 2'b00) return 0;
        if (!m_impl(i_csr)) return 1;
        return (i_csr >= 12'hC00) && (i_csr_op == 2'b01 || i_wd != 0);
    endfunction

    task automatic model_step();
        logic [31:0] old, nv;
        logic [63:0] pc, pi;
        bit we, p_mie, p_mpie;
        old = m_read(i_csr);
        nv = (i_csr_op == 2'b01) ? i_wd : (i_csr_op == 2'b10) ? (old | i_wd) : (old & ~i_wd);
        we = (i_csr_op != 0) && !m_illegal();
        pc = m_cyc; pi = m_inst; p_mie = m_mie; p_mpie = m_mpie;
        m_cyc = m_cyc + 1;
        if (i_retire) m_inst = m_inst + 1;
        if (we) begin
            case (i_csr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_meie = nv[11];
                12'h305: m_mtvec = nv & ~32'h3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: m_cyc = {pc[63:32], nv};
                12'hB80: m_cyc = {nv, pc[31:0]};
                12'hB02: m_inst = {pi[63:32], nv};
                12'hB82: m_inst = {nv, pi[31:0]};
                default: ;
            endcase
        end
        if (i_trap) begin
            m_mpie = p_mie; m_mie = 0;
            m_mepc = i_trap_pc & ~32'h3; m_mcause = i_trap_cause; m_mtval = i_trap_val;
        end else if (i_mret) begin
            m_mie = p_mpie; m_mpie = 1;
        end
    endtask

    // Called at posedge+1; samples 4 time units later, well before the next edge.
    task automatic sample();
        #4;
        chk("rd", o_rd, m_read(i_csr));
        chk("illegal", {31'b0, o_illegal}, {31'b0, m_illegal()});
        chk("irq_take", {31'b0, o_irq_take}, {31'b0, i_irq_ext & m_meie & m_mie});
        chk("mtvec_o", o_mtvec, m_mtvec);
        chk("mepc_o", o_mepc, m_mepc);
    endtask

    task automatic edge_step();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        sample();
        edge_step();
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        i_csr_op = op; i_csr = a; i_wd = wd;
    endtask

    task automatic clr();
        drive(2'b00, 12'h000, 0);
        i_retire = 0; i_trap = 0; i_mret = 0; i_irq_ext = 0;
        i_trap_cause = 0; i_trap_pc = 0; i_trap_val = 0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        ill;
    } vec_t;

    vec_t vt[16];
    logic [11:0] addrs[17];

    initial begin
        vt[0]  = '{2'b00, 12'h300, 32'h0,         32'h0000_1800, 1'b0};
        vt[1]  = '{2'b00, 12'h305, 32'h0,         TVEC_RST,      1'b0};
        vt[2]  = '{2'b00, 12'hF14, 32'h0,         HART,          1'b0};
        vt[3]  = '{2'b01, 12'h340, 32'hA5A5_0000, 32'h0,         1'b0};
        vt[4]  = '{2'b10, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b0};
        vt[5]  = '{2'b11, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b0};
        vt[6]  = '{2'b00, 12'h340, 32'h0,         32'h00A5_00FF, 1'b0};
        vt[7]  = '{2'b01, 12'hF14, 32'h1,         HART,          1'b1};
        vt[8]  = '{2'b10, 12'hF14, 32'h0,         HART,          1'b0};
        vt[9]  = '{2'b11, 12'hF14, 32'h4,         HART,          1'b1};
        vt[10] = '{2'b10, 12'h7C0, 32'h0,         32'h0,         1'b1};
        vt[11] = '{2'b00, 12'h7C0, 32'h0,         32'h0,         1'b0};
        vt[12] = '{2'b00, 12'h301, 32'h0,         32'h4000_0100, 1'b0};
        vt[13] = '{2'b01, 12'h305, 32'h0000_0203, TVEC_RST,      1'b0};
        vt[14] = '{2'b01, 12'h341, 32'h0000_1237, 32'h0,         1'b0};
        vt[15] = '{2'b00, 12'h341, 32'h0,         32'h0000_1234, 1'b0};
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'hF11, 12'h123};

        clr();
        i_rst = 1;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        drive(2'b00, 12'h300, 0);
        #1;
        chk("rst mstatus", o_rd, 32'h0000_1800);
        chk("rst mtvec_o", o_mtvec, TVEC_RST);
        chk("rst mepc_o", o_mepc, 32'h0);
        chk("rst irq_take", {31'b0, o_irq_take}, 32'h0);
        i_rst = 0;

        foreach (vt[i]) begin
            drive(vt[i].op, vt[i].a, vt[i].wd);
            sample();
            chk($sformatf("vec%0d rd", i), o_rd, vt[i].rd);
            chk($sformatf("vec%0d illegal", i), {31'b0, o_illegal}, {31'b0, vt[i].ill});
            edge_step();
        end

        // Interrupt enable, trap entry and mret.
        i_irq_ext = 1;
        drive(2'b01, 12'h300, 32'h8); tick();
        drive(2'b01, 12'h304, 32'h800); tick();
        drive(2'b00, 12'h300, 0);
        i_trap = 1; i_trap_cause = 32'h8000_000B; i_trap_pc = 32'h100; i_trap_val = 32'h55;
        sample();
        chk("irq_take set", {31'b0, o_irq_take}, 32'h1);
        edge_step();
        i_trap = 0;
        sample();
        chk("trap mepc", o_mepc, 32'h100);
        chk("trap mstatus", o_rd, 32'h0000_1880);
        chk("trap irq_take", {31'b0, o_irq_take}, 32'h0);
        edge_step();
        drive(2'b00, 12'h342, 0);
        sample();
        chk("trap mcause", o_rd, 32'h8000_000B);
        i_mret = 1;
        edge_step();
        i_mret = 0;
        drive(2'b00, 12'h300, 0);
        sample();
        chk("mret mstatus", o_rd, 32'h0000_1888);
        edge_step();

        // Trap and mret together, with a competing mstatus write: only the trap lands.
        drive(2'b01, 12'h300, 32'h80); tick();
        drive(2'b01, 12'h300, 32'h88);
        i_trap = 1; i_mret = 1; i_trap_pc = 32'h200;
        tick();
        i_trap = 0; i_mret = 0; i_irq_ext = 0;
        drive(2'b00, 12'h300, 0);
        sample();
        chk("trap+mret mstatus", o_rd, 32'h0000_1800);
        chk("trap+mret mepc", o_mepc, 32'h200);
        edge_step();

        // mcycle low-word write: no carry on the write edge, then wrap.
        drive(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
        drive(2'b00, 12'hB00, 0);
        sample(); chk("mcycle lo written", o_rd, 32'hFFFF_FFFF); edge_step();
        drive(2'b00, 12'hB80, 0);
        sample(); chk("mcycleh carried", o_rd, 32'h1); edge_step();
        drive(2'b00, 12'hB00, 0);
        sample(); chk("mcycle lo wrapped", o_rd, 32'h1); edge_step();

        // minstret counts retire pulses.
        drive(2'b01, 12'hB02, 0); tick();
        drive(2'b00, 12'hB02, 0);
        i_retire = 1;
        repeat (3) tick();
        i_retire = 0;
        sample(); chk("minstret=3", o_rd, 32'h3); edge_step();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            i_csr    = addrs[$urandom_range(0, 16)];
            i_csr_op = 2'($urandom_range(0, 3));
            i_wd     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            i_retire = 1'($urandom);
            i_irq_ext = 1'($urandom);
            i_trap   = ($urandom_range(0, 15) == 0);
            i_mret   = ($urandom_range(0, 15) == 0);
            i_trap_cause = $urandom; i_trap_pc = $urandom; i_trap_val = $urandom;
            tick();
        end
        clr();

        // Asynchronous reset between edges clears the counters at once.
        i_rst = 1;
        #1;
        drive(2'b00, 12'hB00, 0);
        #1; chk("async rst mcycle", o_rd, 32'h0);
        drive(2'b00, 12'hB02, 0);
        #1; chk("async rst minstret", o_rd, 32'h0);
        model_reset();
        i_rst = 0;
        drive(2'b00, 12'hB00, 0);
        sample(); chk("post rst mcycle", o_rd, 32'h0); edge_step();
        sample(); chk("first inc mcycle", o_rd, 32'h1); edge_step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
